bc_regfile_ctx: RTL and testbench

- Parametrised, multi-context register file for the single-cycle core. Holds NUM_CTX complete GPR+HI+LO banks, one per OS process context.
- Keeps the existing write-location encoding, which covers GPR, HI+LO, RA, HI-only and LO-only writes.
- Adds an asynchronous reset, a hardwired zero register, and a context engine. The engine performs an instant bank SWITCH or a multi-cycle CLONE (copy active bank into target bank, then switch). The kernel uses CLONE for fork-style process creation.
- Sits between decode and the ALU/HI-LO unit. Its ctx handshake is driven by the OS control path.

---
 rtl/bc_regfile_ctx.sv | 159 +++++++++++++++
 tb/tb_bc_regfile_ctx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_regfile_ctx.sv
// Multi-context GPR+HI/LO register file with a bank SWITCH/CLONE engine.
// Writes and the engine act on posedge; read ports are registered on negedge.
module bc_regfile_ctx #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_CTX = 4,
   parameter int unsigned CTX_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] write_hi,
   input  logic [DATA_W-1:0] write_lo,
   input  logic [DATA_W-1:0] write_ra,
   input  logic              reg_write,
   input  logic [2:0]        loc_write,
   output logic [DATA_W-1:0] read1,
   output logic [DATA_W-1:0] read2,
   output logic [DATA_W-1:0] bc_hi,
   output logic [DATA_W-1:0] bc_lo,
   input  logic              ctx_req,
   input  logic              ctx_op,
   input  logic [CTX_W-1:0]  ctx_target,
   output logic              ctx_busy,
   output logic              ctx_done,
   output logic [CTX_W-1:0]  cur_ctx,
   input  logic [CTX_W-1:0]  dbg_ctx,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int unsigned NREG   = 2 ** ADDR_W;
   localparam int unsigned BANK_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

   typedef enum logic [1:0] {IDLE, COPY, COPY_HL, DONE} state_t;

   logic [DATA_W-1:0] gpr [NUM_CTX][NREG];
   logic [DATA_W-1:0] hi  [NUM_CTX];
   logic [DATA_W-1:0] lo  [NUM_CTX];

   state_t            state;
   logic [CTX_W-1:0]  tgt;
   logic [ADDR_W-1:0] idx;
   logic [BANK_W-1:0] act_b;
   logic [BANK_W-1:0] tgt_b;
   logic [BANK_W-1:0] dbg_b;
   logic [ADDR_W-1:0] ra_addr;
   logic              req_ok;
   logic              dbg_ok;

   always_comb begin
      act_b   = cur_ctx[BANK_W-1:0];
      tgt_b   = tgt[BANK_W-1:0];
      dbg_b   = dbg_ctx[BANK_W-1:0];
      ra_addr = '1;
      req_ok  = ctx_req && (32'(ctx_target) < NUM_CTX);
      dbg_ok  = 32'(dbg_ctx) < NUM_CTX;
   end

   // Core writes are only possible outside COPY/COPY_HL, so they never collide with the copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned b = 0; b < NUM_CTX; b++) begin
            hi[BANK_W'(b)] <= '0;
            lo[BANK_W'(b)] <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
               gpr[BANK_W'(b)][ADDR_W'(r)] <= '0;
            end
         end
      end else if (state == COPY) begin
         gpr[tgt_b][idx] <= gpr[act_b][idx];
      end else if (state == COPY_HL) begin
         hi[tgt_b] <= hi[act_b];
         lo[tgt_b] <= lo[act_b];
      end else if (reg_write) begin
         case (loc_write)
            3'b000: if (rd != '0) gpr[act_b][rd] <= write_data;
            3'b001: begin
               hi[act_b] <= write_hi;
               lo[act_b] <= write_lo;
            end
            // Link register is the top GPR; guarded in case a tiny ADDR_W aliases it onto r0.
            3'b010: if (ra_addr != '0) gpr[act_b][ra_addr] <= write_ra;
            3'b011: hi[act_b] <= write_data;
            3'b100: lo[act_b] <= write_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cur_ctx  <= '0;
         tgt      <= '0;
         idx      <= '0;
         ctx_busy <= 1'b0;
         ctx_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ctx_done <= 1'b0;
               if (req_ok) begin
                  if (!ctx_op) begin
                     cur_ctx  <= ctx_target;
                     state    <= DONE;
                     ctx_done <= 1'b1;
                  end else if (ctx_target == cur_ctx) begin
                     state    <= DONE;
                     ctx_done <= 1'b1;
                  end else begin
                     tgt      <= ctx_target;
                     idx      <= ADDR_W'(1);
                     state    <= COPY;
                     ctx_busy <= 1'b1;
                  end
               end
            end
            COPY: begin
               idx <= idx + 1'b1;
               if (idx == '1) state <= COPY_HL;
            end
            COPY_HL: begin
               cur_ctx  <= tgt;
               state    <= DONE;
               ctx_busy <= 1'b0;
               ctx_done <= 1'b1;
            end
            DONE: begin
               ctx_done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state    <= IDLE;
               ctx_busy <= 1'b0;
               ctx_done <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         read1    <= '0;
         read2    <= '0;
         bc_hi    <= '0;
         bc_lo    <= '0;
         dbg_data <= '0;
      end else begin
         read1    <= gpr[act_b][rs];
         read2    <= gpr[act_b][rt];
         bc_hi    <= hi[act_b];
         bc_lo    <= lo[act_b];
         dbg_data <= dbg_ok ? gpr[dbg_b][dbg_addr] : '0;
      end
   end
endmodule

// File: tb/tb_bc_regfile_ctx.sv
// Self-checking bench for bc_regfile_ctx: write-location table, SWITCH/CLONE,
// reset mid-clone, same-edge write+clone, held and out-of-range requests.
module tb_bc_regfile_ctx;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NC = 4;
   localparam int unsigned CW = 3;

   localparam int unsigned S_R1 = 0, S_R2 = 1, S_HI = 2, S_LO = 3;
   localparam int unsigned S_DBG = 4, S_CUR = 5, S_BUSY = 6, S_DONE = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rs, rt, rd;
   logic [DW-1:0] write_data, write_hi, write_lo, write_ra;
   logic          reg_write;
   logic [2:0]    loc_write;
   logic [DW-1:0] read1, read2, bc_hi, bc_lo;
   logic          ctx_req, ctx_op;
   logic [CW-1:0] ctx_target;
   logic          ctx_busy, ctx_done;
   logic [CW-1:0] cur_ctx;
   logic [CW-1:0] dbg_ctx;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      string       name;
      int unsigned sel;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [2:0]  loc;
      logic [4:0]  rd;
      logic [31:0] wd, whi, wlo, wra;
      logic [4:0]  rs, rt;
      logic [31:0] e1, e2, ehi, elo;
   } vec_t;
   vec_t vt [11];

   bc_regfile_ctx #(.DATA_W(DW), .ADDR_W(AW), .NUM_CTX(NC), .CTX_W(CW)) dut (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
      .write_data(write_data), .write_hi(write_hi), .write_lo(write_lo), .write_ra(write_ra),
      .reg_write(reg_write), .loc_write(loc_write),
      .read1(read1), .read2(read2), .bc_hi(bc_hi), .bc_lo(bc_lo),
      .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_target(ctx_target),
      .ctx_busy(ctx_busy), .ctx_done(ctx_done), .cur_ctx(cur_ctx),
      .dbg_ctx(dbg_ctx), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] act_val(input int unsigned sel);
      case (sel)
         S_R1:   return read1;
         S_R2:   return read2;
         S_HI:   return bc_hi;
         S_LO:   return bc_lo;
         S_DBG:  return dbg_data;
         S_CUR:  return 32'(cur_ctx);
         S_BUSY: return 32'(ctx_busy);
         default: return 32'(ctx_done);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic push_exp(input string n, input int unsigned s, input logic [31:0] v);
      exp_t x;
      x.name = n;
      x.sel  = s;
      x.val  = v;
      sb.push_back(x);
   endtask

   // Outputs are registered on negedge; compare everything queued shortly after it.
   task automatic flush();
      exp_t x;
      @(negedge clk);
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check(x.name, act_val(x.sel), x.val);
      end
   endtask

   task automatic do_ctx(input logic op, input logic [CW-1:0] t);
      ctx_req    = 1'b1;
      ctx_op     = op;
      ctx_target = t;
      @(posedge clk);
      #1;
      ctx_req = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (ctx_done) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned nbusy;
      logic        saw_done;

      //        we   loc   rd  wd            whi    wlo    wra     rs  rt  e1            e2      ehi    elo
      vt[0]  = '{1'b1, 3'd0, 5, 32'hDEADBEEF, 0,     0,     0,      5, 31, 32'hDEADBEEF, 0,      0,     0};
      vt[1]  = '{1'b1, 3'd1, 0, 0,            32'h11, 32'h22, 0,    5, 31, 32'hDEADBEEF, 0,      32'h11, 32'h22};
      vt[2]  = '{1'b1, 3'd0, 0, 32'hFFFF,     0,     0,     0,      0, 31, 0,            0,      32'h11, 32'h22};
      vt[3]  = '{1'b1, 3'd2, 3, 0,            0,     0,     32'h400, 31, 31, 32'h400,    32'h400, 32'h11, 32'h22};
      vt[4]  = '{1'b1, 3'd3, 5, 32'h33,       0,     0,     0,      5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h22};
      vt[5]  = '{1'b1, 3'd4, 5, 32'h44,       0,     0,     0,      5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h44};
      vt[6]  = '{1'b1, 3'd6, 5, 32'h1234,     32'hAA, 32'hBB, 32'h777, 5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h44};
      vt[7]  = '{1'b1, 3'd5, 5, 32'h1234,     32'hAA, 32'hBB, 32'h777, 5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h44};
      vt[8]  = '{1'b1, 3'd7, 31, 32'h1234,    32'hAA, 32'hBB, 32'h777, 5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h44};
      vt[9]  = '{1'b0, 3'd0, 5, 32'h0,        0,     0,     0,      5, 31, 32'hDEADBEEF, 32'h400, 32'h33, 32'h44};
      vt[10] = '{1'b1, 3'd1, 0, 0,            32'h11, 32'h22, 0,    5, 31, 32'hDEADBEEF, 32'h400, 32'h11, 32'h22};

      reset = 1'b1;
      rs = '0; rt = '0; rd = '0;
      write_data = '0; write_hi = '0; write_lo = '0; write_ra = '0;
      reg_write = 1'b0; loc_write = '0;
      ctx_req = 1'b0; ctx_op = 1'b0; ctx_target = '0;
      dbg_ctx = '0; dbg_addr = '0;

      push_exp("rst_read1", S_R1, 0);
      push_exp("rst_hi", S_HI, 0);
      push_exp("rst_lo", S_LO, 0);
      push_exp("rst_dbg", S_DBG, 0);
      push_exp("rst_cur", S_CUR, 0);
      push_exp("rst_busy", S_BUSY, 0);
      push_exp("rst_done", S_DONE, 0);
      flush();
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         reg_write = vt[i].we;  loc_write = vt[i].loc; rd = vt[i].rd;
         write_data = vt[i].wd; write_hi = vt[i].whi; write_lo = vt[i].wlo; write_ra = vt[i].wra;
         rs = vt[i].rs; rt = vt[i].rt;
         push_exp($sformatf("vec%0d_read1", i), S_R1, vt[i].e1);
         push_exp($sformatf("vec%0d_read2", i), S_R2, vt[i].e2);
         push_exp($sformatf("vec%0d_hi", i), S_HI, vt[i].ehi);
         push_exp($sformatf("vec%0d_lo", i), S_LO, vt[i].elo);
         @(posedge clk);
         #1;
         reg_write = 1'b0;
         flush();
      end

      rs = 5;
      do_ctx(1'b0, 2);
      push_exp("sw2_done", S_DONE, 1);
      push_exp("sw2_cur", S_CUR, 2);
      push_exp("sw2_read1", S_R1, 0);
      push_exp("sw2_hi", S_HI, 0);
      flush();
      push_exp("sw2_done_drop", S_DONE, 0);
      flush();
      do_ctx(1'b0, 0);
      push_exp("sw0_done", S_DONE, 1);
      push_exp("sw0_read1", S_R1, 32'hDEADBEEF);
      push_exp("sw0_hi", S_HI, 32'h11);
      push_exp("sw0_lo", S_LO, 32'h22);
      flush();
      @(posedge clk);
      #1;

      for (int k = 1; k < 32; k++) begin
         reg_write = 1'b1; loc_write = 3'd0; rd = AW'(k); write_data = 32'(k * 3);
         @(posedge clk);
         #1;
      end
      reg_write = 1'b0;

      do_ctx(1'b1, 3);
      reg_write = 1'b1; loc_write = 3'd0; rd = 7; write_data = 32'h55;
      nbusy = 0;
      saw_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (i == 5) reg_write = 1'b0;
         if (ctx_busy) nbusy++;
         else begin
            saw_done = ctx_done;
            break;
         end
      end
      reg_write = 1'b0;
      check("clone_busy_cycles", nbusy, 32);
      check("clone_done_pulse", 32'(saw_done), 1);
      check("clone_cur", 32'(cur_ctx), 3);
      @(posedge clk);
      #1;
      push_exp("clone_done_drop", S_DONE, 0);
      flush();

      do_ctx(1'b1, 3);
      push_exp("noop_clone_done", S_DONE, 1);
      push_exp("noop_clone_busy", S_BUSY, 0);
      push_exp("noop_clone_cur", S_CUR, 3);
      flush();
      @(posedge clk);
      #1;

      dbg_ctx = 0;
      for (int k = 0; k < 32; k++) begin
         rs = AW'(k); dbg_addr = AW'(k);
         push_exp($sformatf("clone_gpr%0d", k), S_R1, 32'(k * 3));
         push_exp($sformatf("src_gpr%0d", k), S_DBG, 32'(k * 3));
         flush();
      end
      push_exp("clone_hi", S_HI, 32'h11);
      push_exp("clone_lo", S_LO, 32'h22);
      flush();

      rs = 31;
      do_ctx(1'b1, 1);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(ctx_busy), 0);
      check("abort_cur", 32'(cur_ctx), 0);
      check("abort_done", 32'(ctx_done), 0);
      check("abort_read1", read1, 0);
      check("abort_hi", bc_hi, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 32; k++) begin
            dbg_ctx = CW'(b); dbg_addr = AW'(k);
            push_exp($sformatf("abort_b%0d_r%0d", b, k), S_DBG, 0);
            flush();
         end
      end
      push_exp("abort_hi_after", S_HI, 0);
      push_exp("abort_lo_after", S_LO, 0);
      flush();

      do_ctx(1'b0, 1);
      wait_done("sw1_done");
      reg_write = 1'b1; loc_write = 3'd0; rd = 9; write_data = 32'hABCD;
      ctx_req = 1'b1; ctx_op = 1'b1; ctx_target = 2;
      @(posedge clk);
      #1;
      ctx_req = 1'b0;
      reg_write = 1'b0;
      wait_done("same_edge_done");
      rs = 9; dbg_ctx = 1; dbg_addr = 9;
      push_exp("same_edge_cur", S_CUR, 2);
      push_exp("same_edge_dst", S_R1, 32'hABCD);
      push_exp("same_edge_src", S_DBG, 32'hABCD);
      flush();

      ctx_req = 1'b1; ctx_op = 1'b0; ctx_target = 1;
      @(posedge clk);
      #1;
      push_exp("held_done0", S_DONE, 1);
      push_exp("held_cur", S_CUR, 1);
      flush();
      push_exp("held_done1", S_DONE, 0);
      flush();
      push_exp("held_done2", S_DONE, 1);
      flush();
      ctx_req = 1'b0;
      @(posedge clk);
      #1;

      do_ctx(1'b0, 5);
      push_exp("oor_sw_done", S_DONE, 0);
      push_exp("oor_sw_cur", S_CUR, 1);
      flush();
      do_ctx(1'b1, 5);
      push_exp("oor_cl_busy", S_BUSY, 0);
      push_exp("oor_cl_done", S_DONE, 0);
      push_exp("oor_cl_cur", S_CUR, 1);
      flush();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
